mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single 256-bit main-memory port between the instruction-cache controller (I side) and the data-cache controller (D side).
- Sits between both cache controllers and the off-chip memory model.
- Grants one line transaction (read-fill or write-back) at a time, round-robin on contention.
- Latches the address and data of the granted request and routes the memory acknowledge and read data back to the owner.

Parameters:
- ADDR_W, 32, line address width.
- LINE_W, 256, cache line / memory data width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- i_req_i  in  1  I-side request; held until i_ack_o
- i_write_i  in  1  I-side write (normally 0)
- i_addr_i  in  ADDR_W  I-side line address
- i_data_i  in  LINE_W  I-side write data
- i_data_o  out  LINE_W  I-side read data, valid with i_ack_o
- i_ack_o  out  1  I-side completion pulse
- d_req_i, d_write_i, d_addr_i, d_data_i, d_data_o, d_ack_o  same as I side, for the D side
- mem_enable_o  out  1  memory request, held for the whole transaction
- mem_write_o  out  1  memory write
- mem_addr_o  out  ADDR_W  memory address
- mem_data_o  out  LINE_W  memory write data
- mem_data_i  in  LINE_W  memory read data
- mem_ack_i  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (async, any time, including mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0.
  - last_grant is set to I, so D wins the first tie.
  - The in-flight memory transaction is abandoned. The memory model is reset by the same rst_i.
- States:
  - IDLE
    - No request: stay in IDLE.
    - One request: go to that side's GRANT state.
    - Both requests: grant the side not equal to last_grant.
    - On entry to GRANT, latch the winner's write/addr/data into mem_write_o/mem_addr_o/mem_data_o registers.
  - GRANT_I / GRANT_D
    - mem_enable_o = 1 and latched fields stay stable.
    - Requests from the other side are ignored.
    - On mem_ack_i: pulse the owner's ack for that same cycle, set last_grant to the owner, go to IDLE.
- Latency:
  - A request sampled in IDLE at edge t drives mem_enable_o high from t+1.
  - mem_ack_i at cycle n gives owner ack in cycle n (combinational).
  - The next grant is asserted at n+2 at the earliest.
  - This enforced IDLE cycle lets the requester drop its stale req after ack, so no double issue occurs.
- Data return:
  - Owner's data_o = mem_data_i while in its GRANT state.
  - The non-owner's data_o = 0.
  - An ack is never given to the non-owner.
- mem_ack_i in IDLE (spurious) is ignored and produces no state change.
- A requester dropping req before ack is a protocol violation. The arbiter still completes the memory transaction and then returns to IDLE.
- Write and read transactions are arbitrated identically.
- The block never asserts both acks in one cycle.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_grants_o[31:0], perf_d_grants_o[31:0] and perf_conflict_o[31:0].
  - perf_i_grants_o / perf_d_grants_o increment on each grant to their side.
  - perf_conflict_o increments on each cycle a request waits while the other side holds the grant.
  - All counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, GRANT_I, GRANT_D};
  - requester id enum {REQ_I, REQ_D};
  - ADDR_W/LINE_W default constants.
- One sub-module, mem_arb_perf, holds the three saturating counters. It is instantiated only under MEM_ARB_PERF_EN.

Test Plan:
- Single I read: i_req=1, addr=0x100, memory acks after 10 cycles -> mem_enable_o high from the next cycle; mem_addr_o=0x100; i_ack_o pulses with i_data_o=mem_data_i; d_ack_o stays 0.
- Simultaneous after reset: i_req=d_req=1 -> D granted first. I is granted 2 cycles after D's ack. Then with both requesting again, D is granted, confirming alternation.
- D write-back during I hold: I granted, d_req=1, d_write=1, d_addr=0x200, d_data=all-0xA5 -> D waits. Once D is granted, mem_write_o=1, mem_addr_o=0x200, mem_data_o=all-0xA5.
- Latch stability: change d_addr_i while D is granted -> mem_addr_o keeps its latched value until the ack.
- Spurious mem_ack_i in IDLE -> no ack outputs and no state change. Async rst_i pulse mid-GRANT -> all outputs 0 immediately, then IDLE. With MEM_ARB_PERF_EN defined, all counters are 0.
- MEM_ARB_PERF_EN defined, 3 I grants and 2 D grants with 12 cycles of contention -> counters read 3, 2, 12.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D main-memory arbiter: FSM states, requester ids, default widths.
// Also holds the saturating increment used by the optional performance counters.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 256;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } req_id_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Saturating grant/conflict counters for mem_arbiter; each input is a single-cycle event.
// Counts update one cycle after the event; no backpressure.
module mem_arb_perf
   import mem_arb_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        grant_i_evt,
   input  logic        grant_d_evt,
   input  logic        conflict_evt,
   output logic [31:0] perf_i_grants_o,
   output logic [31:0] perf_d_grants_o,
   output logic [31:0] perf_conflict_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_i_grants_o <= '0;
         perf_d_grants_o <= '0;
         perf_conflict_o <= '0;
      end else begin
         if (grant_i_evt)  perf_i_grants_o <= sat_inc(perf_i_grants_o);
         if (grant_d_evt)  perf_d_grants_o <= sat_inc(perf_d_grants_o);
         if (conflict_evt) perf_conflict_o <= sat_inc(perf_conflict_o);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin I/D arbiter for one main-memory line port: grant one cycle after req, owner ack = mem_ack_i.
// Requesters hold req until ack; loser waits; one IDLE cycle between grants. Counters under MEM_ARB_PERF_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              i_req_i,
   input  logic              i_write_i,
   input  logic [ADDR_W-1:0] i_addr_i,
   input  logic [LINE_W-1:0] i_data_i,
   output logic [LINE_W-1:0] i_data_o,
   output logic              i_ack_o,
   input  logic              d_req_i,
   input  logic              d_write_i,
   input  logic [ADDR_W-1:0] d_addr_i,
   input  logic [LINE_W-1:0] d_data_i,
   output logic [LINE_W-1:0] d_data_o,
   output logic              d_ack_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]       perf_i_grants_o,
   output logic [31:0]       perf_d_grants_o,
   output logic [31:0]       perf_conflict_o
`endif
);

   state_t  state_q, state_d;
   req_id_t last_q, last_d;
   req_id_t win;
   logic    grant_evt;

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      win       = REQ_I;
      grant_evt = 1'b0;
      i_ack_o   = 1'b0;
      d_ack_o   = 1'b0;
      case (state_q)
         IDLE: begin
            // On a tie the side that did not own the last transaction wins.
            if (i_req_i && d_req_i) begin
               win       = (last_q == REQ_I) ? REQ_D : REQ_I;
               grant_evt = 1'b1;
            end else if (d_req_i) begin
               win       = REQ_D;
               grant_evt = 1'b1;
            end else if (i_req_i) begin
               win       = REQ_I;
               grant_evt = 1'b1;
            end
            if (grant_evt) state_d = (win == REQ_D) ? GRANT_D : GRANT_I;
         end
         GRANT_I: begin
            if (mem_ack_i) begin
               i_ack_o = 1'b1;
               last_d  = REQ_I;
               state_d = IDLE;
            end
         end
         GRANT_D: begin
            if (mem_ack_i) begin
               d_ack_o = 1'b1;
               last_d  = REQ_D;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         last_q      <= REQ_I;
         mem_write_o <= 1'b0;
         mem_addr_o  <= '0;
         mem_data_o  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         // Request fields are captured once so the memory sees a stable transaction.
         if (grant_evt) begin
            mem_write_o <= (win == REQ_D) ? d_write_i : i_write_i;
            mem_addr_o  <= (win == REQ_D) ? d_addr_i  : i_addr_i;
            mem_data_o  <= (win == REQ_D) ? d_data_i  : i_data_i;
         end
      end
   end

   assign mem_enable_o = (state_q != IDLE);
   assign i_data_o     = (state_q == GRANT_I) ? mem_data_i : '0;
   assign d_data_o     = (state_q == GRANT_D) ? mem_data_i : '0;

`ifdef MEM_ARB_PERF_EN
   logic conflict_evt;

   assign conflict_evt = ((state_q == GRANT_I) && d_req_i) ||
                         ((state_q == GRANT_D) && i_req_i);

   mem_arb_perf u_perf (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .grant_i_evt     (grant_evt && (win == REQ_I)),
      .grant_d_evt     (grant_evt && (win == REQ_D)),
      .conflict_evt    (conflict_evt),
      .perf_i_grants_o (perf_i_grants_o),
      .perf_d_grants_o (perf_d_grants_o),
      .perf_conflict_o (perf_conflict_o)
   );
`endif

endmodule
